// File: rtl/wb_arb.sv
// Writeback arbiter: merges ALU, LSU and MUL/DIV results onto the single register file write port.
// Fixed priority src0 > src1 > src2, with a per-source starvation override. Writes to x0 are acked and dropped.
module wb_arb #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s0_valid,
  output logic            s0_ready,
  input  logic [4:0]      s0_dst,
  input  logic [XLEN-1:0] s0_data,
  input  logic            s1_valid,
  output logic            s1_ready,
  input  logic [4:0]      s1_dst,
  input  logic [XLEN-1:0] s1_data,
  input  logic            s2_valid,
  output logic            s2_ready,
  input  logic [4:0]      s2_dst,
  input  logic [XLEN-1:0] s2_data,
  output logic            rf_wen,
  output logic [4:0]      rf_wdst,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int WW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [WW-1:0] LIMIT = WW'(STARVE_LIMIT);

  // Handshake: a transfer occurs when sN_valid & sN_ready on a rising clk edge.
  // sN_ready is combinational; a source holds valid/dst/data until accepted.
  logic [2:0]      valid;
  logic [2:0]      req;
  logic [2:0]      starv;
  logic [2:0]      grant;
  logic [2:0]      x0;
  logic [4:0]      dst      [3];
  logic [XLEN-1:0] data     [3];
  logic [WW-1:0]   wait_cnt [3];
  logic [4:0]      sel_dst;
  logic [XLEN-1:0] sel_data;

  assign valid   = {s2_valid, s1_valid, s0_valid};
  assign dst[0]  = s0_dst;
  assign dst[1]  = s1_dst;
  assign dst[2]  = s2_dst;
  assign data[0] = s0_data;
  assign data[1] = s1_data;
  assign data[2] = s2_data;

  always_comb begin
    req   = '0;
    starv = '0;
    x0    = '0;
    for (int i = 0; i < 3; i++) begin
      req[i]   = valid[i] & (dst[i] != 5'd0);
      x0[i]    = valid[i] & (dst[i] == 5'd0);
      starv[i] = req[i] & (wait_cnt[i] == LIMIT);
    end
  end

  // A starving source overrides normal order; among starving sources the lowest index wins.
  always_comb begin
    grant = '0;
    if (starv[0])      grant = 3'b001;
    else if (starv[1]) grant = 3'b010;
    else if (starv[2]) grant = 3'b100;
    else if (req[0])   grant = 3'b001;
    else if (req[1])   grant = 3'b010;
    else if (req[2])   grant = 3'b100;
  end

  assign s0_ready = !rst & (grant[0] | x0[0]);
  assign s1_ready = !rst & (grant[1] | x0[1]);
  assign s2_ready = !rst & (grant[2] | x0[2]);

  always_comb begin
    sel_dst  = dst[0];
    sel_data = data[0];
    if (grant[1]) begin
      sel_dst  = dst[1];
      sel_data = data[1];
    end else if (grant[2]) begin
      sel_dst  = dst[2];
      sel_data = data[2];
    end
  end

  // Counts consecutive lost cycles; any cycle without a real request restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (grant[i] | !req[i])
          wait_cnt[i] <= '0;
        else if (wait_cnt[i] != LIMIT)
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_wdst  <= 5'd0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= |grant;
      if (|grant) begin
        rf_wdst  <= sel_dst;
        rf_wdata <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arb.sv
// Directed and randomised checks for wb_arb: reset, single write, priority, x0 drop,
// starvation override and a scoreboard over random traffic.
module tb_wb_arb;

  localparam int XLEN         = 64;
  localparam int STARVE_LIMIT = 4;

  logic            clk;
  logic            rst;
  logic            s0_valid, s1_valid, s2_valid;
  logic            s0_ready, s1_ready, s2_ready;
  logic [4:0]      s0_dst, s1_dst, s2_dst;
  logic [XLEN-1:0] s0_data, s1_data, s2_data;
  logic            rf_wen;
  logic [4:0]      rf_wdst;
  logic [XLEN-1:0] rf_wdata;

  int n_vec = 0;
  int n_err = 0;

  logic [XLEN+4:0] exp_q[$];

  wb_arb #(.XLEN(XLEN), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_dst(s0_dst), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_dst(s1_dst), .s1_data(s1_data),
    .s2_valid(s2_valid), .s2_ready(s2_ready), .s2_dst(s2_dst), .s2_data(s2_data),
    .rf_wen(rf_wen), .rf_wdst(rf_wdst), .rf_wdata(rf_wdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s0_valid = 0; s1_valid = 0; s2_valid = 0;
    s0_dst = 0; s1_dst = 0; s2_dst = 0;
    s0_data = 0; s1_data = 0; s2_data = 0;
  endtask

  // random-phase source state
  logic            rv   [3];
  logic [4:0]      rdst [3];
  logic [XLEN-1:0] rdat [3];
  int              pend [3];

  task automatic drive();
    s0_valid = rv[0]; s0_dst = rdst[0]; s0_data = rdat[0];
    s1_valid = rv[1]; s1_dst = rdst[1]; s1_data = rdat[1];
    s2_valid = rv[2]; s2_dst = rdst[2]; s2_data = rdat[2];
  endtask

  logic [2:0] t5_g [11] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100,
                            3'b001, 3'b001, 3'b001, 3'b010, 3'b100};
  logic [4:0] t5_d [11] = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd2, 5'd9,
                            5'd1, 5'd1, 5'd1, 5'd2, 5'd10};

  initial begin
    logic [2:0]      r;
    logic [2:0]      acc;
    logic [XLEN+4:0] e;
    int              nacc;
    logic            any_req;

    rst = 1'b1;
    idle();
    s0_valid = 1; // x0 request must not be acked during reset
    tick(); tick();
    check("rst_wen",   rf_wen, 0);
    check("rst_wdst",  rf_wdst, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_ready", {s2_ready, s1_ready, s0_ready}, 0);
    idle();
    rst = 1'b0;
    tick();
    check("idle_wen", rf_wen, 0);

    // single LSU write
    s1_valid = 1; s1_dst = 7; s1_data = 64'hDEAD_BEEF;
    #1;
    check("t2_ready", {s2_ready, s1_ready, s0_ready}, 3'b010);
    tick();
    s1_valid = 0;
    check("t2_wen",   rf_wen, 1);
    check("t2_wdst",  rf_wdst, 7);
    check("t2_wdata", rf_wdata, 64'hDEAD_BEEF);

    // fixed priority, each source drops valid once accepted
    s0_valid = 1; s0_dst = 1; s0_data = 64'h11;
    s1_valid = 1; s1_dst = 2; s1_data = 64'h22;
    s2_valid = 1; s2_dst = 3; s2_data = 64'h33;
    for (int k = 0; k < 3; k++) begin
      #1;
      r = {s2_ready, s1_ready, s0_ready};
      check("t3_ready", r, 3'b001 << k);
      tick();
      if (r[0]) s0_valid = 0;
      if (r[1]) s1_valid = 0;
      if (r[2]) s2_valid = 0;
      check("t3_wen",   rf_wen, 1);
      check("t3_wdst",  rf_wdst, 5'(k + 1));
      check("t3_wdata", rf_wdata, 64'h11 * (k + 1));
    end

    // simultaneous x0 requests: both acked, no write, outputs hold
    idle();
    s0_valid = 1; s2_valid = 1; s0_data = 64'hAAAA; s2_data = 64'hBBBB;
    #1;
    check("t4_ready", {s2_ready, s1_ready, s0_ready}, 3'b101);
    tick();
    idle();
    check("t4_wen",   rf_wen, 0);
    check("t4_wdst",  rf_wdst, 3);
    check("t4_wdata", rf_wdata, 64'h33);

    // reset asserted while s0 is being granted
    s0_valid = 1; s0_dst = 5; s0_data = 64'h5555;
    #1;
    check("t1_ready_pre", s0_ready, 1);
    rst = 1'b1;
    #1;
    check("t1_ready_rst", s0_ready, 0);
    tick();
    check("t1_wen",   rf_wen, 0);
    check("t1_wdst",  rf_wdst, 0);
    check("t1_wdata", rf_wdata, 0);
    check("t1_ready_hold", s0_ready, 0);
    idle();
    rst = 1'b0;
    tick();
    check("t1_wen_after", rf_wen, 0);

    // starvation: s0/s1 always requesting, s2 forced through after STARVE_LIMIT losses
    s0_valid = 1; s0_dst = 1; s0_data = 64'h100;
    s1_valid = 1; s1_dst = 2; s1_data = 64'h200;
    s2_valid = 1; s2_dst = 9; s2_data = 64'h900;
    for (int c = 0; c < 11; c++) begin
      #1;
      check("t5_grant", {s2_ready, s1_ready, s0_ready}, t5_g[c]);
      tick();
      check("t5_wen",  rf_wen, 1);
      check("t5_wdst", rf_wdst, t5_d[c]);
      if (c == 5) begin
        s2_dst = 10; s2_data = 64'hA00;
      end
    end
    check("t5_wdata", rf_wdata, 64'hA00);
    idle();
    tick();
    check("t5_drain", rf_wen, 0);

    // random traffic against a scoreboard
    for (int i = 0; i < 3; i++) begin
      rv[i] = 0; rdst[i] = 0; rdat[i] = 0; pend[i] = 0;
    end
    acc = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!rv[i] || acc[i]) begin
          rv[i]   = ($urandom_range(0, 3) != 0);
          rdst[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          rdat[i] = {$urandom, $urandom};
        end
      end
      drive();
      #1;
      r       = {s2_ready, s1_ready, s0_ready};
      nacc    = 0;
      any_req = 0;
      for (int i = 0; i < 3; i++) begin
        acc[i] = rv[i] & r[i];
        if (r[i] && !rv[i]) check("rnd_ready_no_valid", r[i], 0);
        if (rv[i] && rdst[i] == 0) check("rnd_x0_ack", r[i], 1);
        if (rv[i] && rdst[i] != 0) begin
          any_req = 1;
          if (acc[i]) begin
            nacc++;
            check("rnd_wait_bound", pend[i] <= STARVE_LIMIT + 3, 1);
            exp_q.push_back({rdst[i], rdat[i]});
            pend[i] = 0;
          end else begin
            pend[i]++;
          end
        end
      end
      check("rnd_one_grant", nacc, any_req ? 1 : 0);
      tick();
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rnd_wen",   rf_wen, 1);
        check("rnd_wdst",  rf_wdst, e[XLEN+4:XLEN]);
        check("rnd_wdata", rf_wdata, e[XLEN-1:0]);
      end else begin
        check("rnd_no_wen", rf_wen, 0);
      end
    end
    idle();
    tick();
    check("rnd_drain", rf_wen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
